// File: rtl/temp_sample_filter.sv
`default_nettype none
// ============================================================================
// Module   : temp_sample_filter
// Purpose  : Resynchronise and stability-filter the I2C temperature byte,
//            sample it at SAMPLE_HZ and output a moving average. Optional
//            min/max tracking is built when TEMP_MINMAX_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module temp_sample_filter #(
    parameter int CLK_HZ        = 25_000_000,
    parameter int SAMPLE_HZ     = 10,
    parameter int AVG_LOG2      = 3,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] temp_raw,
    input  logic       minmax_clr,
    output logic [7:0] temp_avg,
    output logic [7:0] temp_min,
    output logic [7:0] temp_max,
    output logic       sample_valid,
    output logic       ready
);

    localparam int c_div    = CLK_HZ / SAMPLE_HZ;
    localparam int c_div_w  = $clog2(c_div);
    localparam int c_depth  = 2 ** AVG_LOG2;
    localparam int c_sum_w  = 8 + AVG_LOG2;
    localparam int c_stab_w = $clog2(STABLE_CYCLES + 1);

    logic [7:0]          r_meta;
    logic [7:0]          r_sync;
    logic [7:0]          r_sync_prev;
    logic [7:0]          r_stable;
    logic [c_stab_w-1:0] r_stab_cnt;
    logic [c_stab_w-1:0] w_stab_cnt_next;

    always_comb begin
        w_stab_cnt_next = '0;
        if (r_sync == r_sync_prev) begin
            if (r_stab_cnt == c_stab_w'(STABLE_CYCLES)) begin
                w_stab_cnt_next = r_stab_cnt;
            end else begin
                w_stab_cnt_next = r_stab_cnt + c_stab_w'(1);
            end
        end
    end

    // Two-flop resync per bit; a byte is accepted only after an unbroken run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta      <= 8'h00;
            r_sync      <= 8'h00;
            r_sync_prev <= 8'h00;
            r_stab_cnt  <= '0;
            r_stable    <= 8'h00;
        end else begin
            r_meta      <= temp_raw;
            r_sync      <= r_meta;
            r_sync_prev <= r_sync;
            r_stab_cnt  <= w_stab_cnt_next;
            if (w_stab_cnt_next == c_stab_w'(STABLE_CYCLES)) begin
                r_stable <= r_sync;
            end
        end
    end

    logic [c_div_w-1:0] r_div_cnt;
    logic               w_tick;

    assign w_tick = (r_div_cnt == c_div_w'(c_div - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + c_div_w'(1);
        end
    end

    logic [7:0]          r_buf [c_depth];
    logic [AVG_LOG2-1:0] r_wp;
    logic [c_sum_w-1:0]  r_sum;
    logic [c_sum_w-1:0]  w_sum_next;

    assign w_sum_next = r_sum - c_sum_w'(r_buf[r_wp]) + c_sum_w'(r_stable);

    // The first tick preloads the whole window so the average starts settled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_buf[i] <= 8'h00;
            end
            r_wp         <= '0;
            r_sum        <= '0;
            temp_avg     <= 8'h00;
            sample_valid <= 1'b0;
            ready        <= 1'b0;
        end else begin
            sample_valid <= w_tick;
            if (w_tick) begin
                if (!ready) begin
                    for (int i = 0; i < c_depth; i++) begin
                        r_buf[i] <= r_stable;
                    end
                    r_sum    <= c_sum_w'(r_stable) << AVG_LOG2;
                    r_wp     <= AVG_LOG2'(1);
                    temp_avg <= r_stable;
                    ready    <= 1'b1;
                end else begin
                    r_buf[r_wp] <= r_stable;
                    r_sum       <= w_sum_next;
                    r_wp        <= r_wp + AVG_LOG2'(1);
                    temp_avg    <= w_sum_next[AVG_LOG2 +: 8];
                end
            end
        end
    end

`ifdef TEMP_MINMAX_EN
    logic r_clr_pend;
    logic w_clr;

    // A clear arriving on the tick cycle itself applies to that tick.
    assign w_clr = r_clr_pend | minmax_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            temp_min   <= 8'h00;
            temp_max   <= 8'h00;
            r_clr_pend <= 1'b0;
        end else if (w_tick) begin
            r_clr_pend <= 1'b0;
            if (!ready || w_clr) begin
                temp_min <= r_stable;
                temp_max <= r_stable;
            end else begin
                if (r_stable < temp_min) begin
                    temp_min <= r_stable;
                end
                if (r_stable > temp_max) begin
                    temp_max <= r_stable;
                end
            end
        end else if (minmax_clr) begin
            r_clr_pend <= 1'b1;
        end
    end
`else
    logic w_unused_clr;

    assign w_unused_clr = minmax_clr;
    assign temp_min     = 8'h00;
    assign temp_max     = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_temp_sample_filter.sv
`default_nettype none
// Testbench for temp_sample_filter: directed temperature steps, expected
// samples queued by the stimulus and checked by a monitor on sample_valid.
module tb_temp_sample_filter;

    typedef struct packed {
        logic [7:0] avg;
        logic [7:0] mn;
        logic [7:0] mx;
    } exp_t;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       minmax_clr = 1'b0;
    logic [7:0] temp_raw   = 8'd0;
    logic [7:0] temp_avg;
    logic [7:0] temp_min;
    logic [7:0] temp_max;
    logic       sample_valid;
    logic       ready;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_seen   = 0;
    int   tgt      = 0;

    temp_sample_filter #(
        .CLK_HZ        (1000),
        .SAMPLE_HZ     (100),
        .AVG_LOG2      (2),
        .STABLE_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .temp_raw     (temp_raw),
        .minmax_clr   (minmax_clr),
        .temp_avg     (temp_avg),
        .temp_min     (temp_min),
        .temp_max     (temp_max),
        .sample_valid (sample_valid),
        .ready        (ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mm(input logic [7:0] v);
`ifdef TEMP_MINMAX_EN
        return v;
`else
        return 8'h00;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && sample_valid) begin
            n_seen++;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample actual_avg=%0d required=no_sample", temp_avg);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("avg[%0d]", n_seen), 32'(temp_avg), 32'(e.avg));
                check($sformatf("min[%0d]", n_seen), 32'(temp_min), 32'(e.mn));
                check($sformatf("max[%0d]", n_seen), 32'(temp_max), 32'(e.mx));
                check($sformatf("ready[%0d]", n_seen), 32'(ready), 32'd1);
            end
        end
    end

    task automatic wait_samples();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (n_seen >= tgt) return;
        end
        checks++;
        failures++;
        $display("FAIL sample_timeout actual=%0d required=%0d", n_seen, tgt);
    endtask

    task automatic expect_sample(input logic [7:0] a, input logic [7:0] mn, input logic [7:0] mx);
        exp_t e;
        e.avg = a;
        e.mn  = mm(mn);
        e.mx  = mm(mx);
        sb_q.push_back(e);
        tgt++;
    endtask

    task automatic step(input logic [7:0] v, input logic [7:0] a, input logic [7:0] mn, input logic [7:0] mx);
        temp_raw = v;
        expect_sample(a, mn, mx);
        wait_samples();
    endtask

    task automatic check_first_latency(input string name);
        int cyc;
        cyc = 0;
        while (cyc < 30) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (sample_valid) break;
        end
        check(name, 32'(cyc), 32'd10);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_avg"}, 32'(temp_avg), 32'd0);
        check({tag, "_min"}, 32'(temp_min), 32'd0);
        check({tag, "_max"}, 32'(temp_max), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_valid"}, 32'(sample_valid), 32'd0);
    endtask

    initial begin
        temp_raw = 8'd25;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");

        expect_sample(8'd25, 8'd25, 8'd25);
        @(posedge clk);
        #1 rst = 1'b0;
        check_first_latency("first_valid_latency");
        @(posedge clk);
        #1;

        // Settle to 20: partial means of a 25-filled window.
        step(8'd20, 8'd23, 8'd20, 8'd25);
        step(8'd20, 8'd22, 8'd20, 8'd25);
        step(8'd20, 8'd21, 8'd20, 8'd25);
        step(8'd20, 8'd20, 8'd20, 8'd25);

        step(8'd28, 8'd22, 8'd20, 8'd28);
        step(8'd28, 8'd24, 8'd20, 8'd28);
        step(8'd28, 8'd26, 8'd20, 8'd28);
        step(8'd28, 8'd28, 8'd20, 8'd28);

        step(8'd25, 8'd27, 8'd20, 8'd28);
        step(8'd25, 8'd26, 8'd20, 8'd28);
        step(8'd25, 8'd25, 8'd20, 8'd28);
        step(8'd25, 8'd25, 8'd20, 8'd28);

        // Input chatter every 2 cycles must never be accepted.
        for (int k = 0; k < 3; k++) expect_sample(8'd25, 8'd20, 8'd28);
        temp_raw = 8'd30;
        for (int c = 0; c < 60 && n_seen < tgt; c++) begin
            @(posedge clk);
            #1;
            if (n_seen < tgt && (c % 2) == 1) temp_raw = (temp_raw == 8'd30) ? 8'd31 : 8'd30;
        end
        check("toggle_samples_seen", 32'(n_seen), 32'(tgt));

        step(8'd40, 8'd28, 8'd20, 8'd40);
        step(8'd22, 8'd28, 8'd20, 8'd40);

        // Clear pulse placed on the tick cycle (9 cycles after the last sample edge).
        expect_sample(8'd27, 8'd22, 8'd22);
        repeat (8) @(posedge clk);
        #1 minmax_clr = 1'b1;
        @(posedge clk);
        #1 minmax_clr = 1'b0;
        wait_samples();
        step(8'd22, 8'd26, 8'd22, 8'd22);

        // Mid-window reset: history dropped, next tick preloads the window.
        temp_raw = 8'd33;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("midreset");
        expect_sample(8'd33, 8'd33, 8'd33);
        check_first_latency("post_reset_latency");
        @(posedge clk);
        #1;
        step(8'd33, 8'd33, 8'd33, 8'd33);

        repeat (3) @(posedge clk);
        check("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
